countdown_timer: RTL and testbench

Loadable down-counting timer: complement of the up-counting modulus tick timer. A start request loads a count, each `incr` strobe decrements it, and a one-cycle `done` pulse fires when the count reaches zero. An optional auto-reload mode turns the block into a programmable-period tick generator. It sits beside the up-counting timers in the timing/control path and consumes the same `incr` enable strobes.

---
 rtl/countdown_timer.sv | 105 ++++++++++
 tb/tb_countdown_timer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counting timer: start loads a count, each incr strobe decrements it,
// and done pulses for one cycle at expiry. Auto-reload turns it into a periodic tick source.
module countdown_timer #(
  parameter int MODULUS = 10,
  parameter int NBITS   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] load_value,
  input  logic             reload,
  input  logic             incr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [NBITS-1:0] MAX_COUNT = NBITS'(MODULUS - 1);
  localparam logic [NBITS-1:0] ONE       = NBITS'(1);
  localparam logic [NBITS-1:0] ZERO      = '0;
  localparam logic [NBITS:0]   MOD_EXT   = (NBITS + 1)'(MODULUS);

  state_t           state, state_n;
  logic [NBITS-1:0] rem_q, rem_n;
  logic [NBITS-1:0] period_q, period_n;
  logic             reload_q, reload_n;
  logic             done_q, done_n;
  logic [NBITS-1:0] clamped;

  // Out-of-range loads saturate to the largest legal count instead of wrapping.
  always_comb begin
    clamped = load_value;
    if ({1'b0, load_value} >= MOD_EXT) clamped = MAX_COUNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rem_q    <= ZERO;
      period_q <= ZERO;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      rem_q    <= rem_n;
      period_q <= period_n;
      reload_q <= reload_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    rem_n    = rem_q;
    period_n = period_q;
    reload_n = reload_q;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (clamped == ZERO) begin
            // Zero-length run expires immediately without ever going busy.
            done_n = 1'b1;
          end else begin
            rem_n    = clamped;
            period_n = clamped;
            reload_n = reload;
            state_n  = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n  = IDLE;
          rem_n    = ZERO;
          reload_n = 1'b0;
        end else if (incr) begin
          if (rem_q > ONE) begin
            rem_n = rem_q - ONE;
          end else if (rem_q == ONE) begin
            done_n = 1'b1;
            if (reload_q) begin
              rem_n = period_q;
            end else begin
              rem_n   = ZERO;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (MODULUS=10).
module tb_countdown_timer;

  localparam int MODULUS = 10;
  localparam int NBITS   = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [NBITS-1:0] load_value;
  logic             reload;
  logic             incr;
  logic             abort;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] remaining;

  int n_checks = 0;
  int n_pass   = 0;

  countdown_timer #(.MODULUS(MODULUS), .NBITS(NBITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_value (load_value),
    .reload     (reload),
    .incr       (incr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one active edge; inputs are driven and outputs sampled 1ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic b, input logic d, input int r);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".remaining"}, 32'(remaining), 32'(r));
  endtask

  task automatic idle_inputs();
    start = 1'b0; load_value = '0; reload = 1'b0; incr = 1'b0; abort = 1'b0;
  endtask

  int exp_rem;
  int done_cnt;

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    expect_out("reset", 1'b0, 1'b0, 0);
    cycle();
    cycle();
    rst = 1'b0;

    // Load 3, incr every cycle: 3,2,1,0 with done on the 0 cycle.
    start = 1'b1; load_value = 4'd3; incr = 1'b1;
    cycle();
    start = 1'b0;
    expect_out("load3.c1", 1'b1, 1'b0, 3);
    cycle();
    expect_out("load3.c2", 1'b1, 1'b0, 2);
    cycle();
    expect_out("load3.c3", 1'b1, 1'b0, 1);
    cycle();
    expect_out("load3.expire", 1'b0, 1'b1, 0);
    incr = 1'b0;
    cycle();
    expect_out("load3.after", 1'b0, 1'b0, 0);

    // Reload mode, period 4, incr every other cycle -> done every 8 cycles.
    start = 1'b1; load_value = 4'd4; reload = 1'b1;
    cycle();
    start = 1'b0; reload = 1'b0;
    expect_out("rl.start", 1'b1, 1'b0, 4);
    exp_rem = 4;
    done_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      incr = (i % 2 == 0);
      cycle();
      if (i % 2 == 0) begin
        if (exp_rem == 1) exp_rem = 4;
        else exp_rem = exp_rem - 1;
      end
      if (done) done_cnt++;
      expect_out($sformatf("rl.i%0d", i), 1'b1, (i % 8 == 6), exp_rem);
    end
    check("rl.done_count", 32'(done_cnt), 32'd3);
    incr = 1'b0; abort = 1'b1;
    cycle();
    abort = 1'b0;
    expect_out("rl.abort", 1'b0, 1'b0, 0);
    incr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      expect_out($sformatf("rl.post%0d", i), 1'b0, 1'b0, 0);
    end
    incr = 1'b0;

    // Zero load: done next cycle, never busy.
    start = 1'b1; load_value = 4'd0; reload = 1'b1;
    cycle();
    start = 1'b0; reload = 1'b0;
    expect_out("zero.done", 1'b0, 1'b1, 0);
    cycle();
    expect_out("zero.after", 1'b0, 1'b0, 0);

    // Load 15 clamps to 9.
    start = 1'b1; load_value = 4'd15;
    cycle();
    expect_out("clamp", 1'b1, 1'b0, 9);
    // start with 7 during RUN is ignored while counting continues.
    load_value = 4'd7; incr = 1'b1;
    cycle();
    start = 1'b0;
    expect_out("ignore_start", 1'b1, 1'b0, 8);
    for (int i = 0; i < 7; i++) cycle();
    incr = 1'b0;
    expect_out("at_one", 1'b1, 1'b0, 1);
    // Abort and final incr together: abort wins.
    abort = 1'b1; incr = 1'b1;
    cycle();
    abort = 1'b0; incr = 1'b0;
    expect_out("abort_final", 1'b0, 1'b0, 0);
    cycle();
    expect_out("abort_final.after", 1'b0, 1'b0, 0);

    // Back-to-back restart in the done cycle.
    start = 1'b1; load_value = 4'd2; incr = 1'b1;
    cycle();
    start = 1'b0;
    expect_out("b2b.a1", 1'b1, 1'b0, 2);
    cycle();
    expect_out("b2b.a2", 1'b1, 1'b0, 1);
    cycle();
    expect_out("b2b.adone", 1'b0, 1'b1, 0);
    start = 1'b1; load_value = 4'd2;
    cycle();
    start = 1'b0;
    expect_out("b2b.b1", 1'b1, 1'b0, 2);
    cycle();
    expect_out("b2b.b2", 1'b1, 1'b0, 1);
    cycle();
    expect_out("b2b.bdone", 1'b0, 1'b1, 0);
    incr = 1'b0;
    cycle();

    // Asynchronous reset mid-run at remaining=5.
    start = 1'b1; load_value = 4'd7;
    cycle();
    start = 1'b0; incr = 1'b1;
    cycle();
    cycle();
    expect_out("arst.pre", 1'b1, 1'b0, 5);
    #2;
    rst = 1'b1;
    #1;
    expect_out("arst.async", 1'b0, 1'b0, 0);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      expect_out($sformatf("arst.post%0d", i), 1'b0, 1'b0, 0);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
